hub75_scan_scheduler: RTL and testbench
=======================================

// Module: hub75_scan_scheduler
// PURPOSE
//  Frame sequencer for the HUB75 row driver. Walks rows x bit-planes (BCM order: for each row,
//  planes 0..PLANES-1), issues one shift/latch order per row-plane, tracks the column being
//  clocked out, and times each plane's lit interval (BASE_SHOW<<plane) before the next order.
//  Sits between the framebuffer read side (uses out_ROW/out_PLANE/out_COL) and the driver FSM.
// PARAMETERS
//  ROWS       32  scan rows per panel half (ROW_BITS=$clog2(ROWS))
//  PLANES     8   BCM bit-planes per colour (PLANE_BITS=$clog2(PLANES))
//  COLS       64  columns shifted per order (COL_BITS=$clog2(COLS))
//  BASE_SHOW  64  lit clocks for plane 0; hold counter width = $clog2(BASE_SHOW<<(PLANES-1))+1
// PORTS
//  clk             in   1           system clock, all state on posedge
//  rst             in   1           asynchronous, active-low reset
//  in_ENABLE       in   1           run scanning while high
//  in_HUB_WAITING  in   1           driver idle/accepting orders (driver ctl_HUB75_WAITING)
//  in_ITER         in   1           driver column-advance strobe (driver ctl_CLOKER_ITER)
//  out_INIT        out  1           order to driver (driver in_INIT), level until acknowledged
//  out_ROW         out  ROW_BITS    row being shifted/shown (driver in_ROW)
//  out_PLANE       out  PLANE_BITS  bit-plane being shifted
//  out_COL         out  COL_BITS    column address for framebuffer fetch
//  out_FRAME_DONE  out  1           1-cycle pulse after last row/last plane hold ends
//  out_BUSY        out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; out_INIT=0, out_ROW=0, out_PLANE=0, out_COL=0,
//   out_FRAME_DONE=0, out_BUSY=0, hold counter=0. All outputs registered.
//  States: IDLE, ISSUE, ACK, SHIFT, HOLD, ADVANCE.
//   IDLE:    in_ENABLE & in_HUB_WAITING -> ISSUE.
//   ISSUE:   out_INIT=1, out_COL<=0 -> ACK.
//   ACK:     out_INIT held 1 until in_HUB_WAITING=0 seen; that cycle drop out_INIT -> SHIFT.
//   SHIFT:   each cycle with in_ITER=1: out_COL<=out_COL+1, wraps COLS-1 -> 0.
//            in_HUB_WAITING=1 (driver latched, panel lit) -> HOLD, load hold=BASE_SHOW<<out_PLANE.
//   HOLD:    hold decrements each cycle; at hold==1 -> ADVANCE (exactly BASE_SHOW<<plane
//            cycles in HOLD).
//   ADVANCE: plane<PLANES-1: plane++. else plane<=0, row++ (ROWS-1 wraps to 0, pulse
//            out_FRAME_DONE). Then in_ENABLE ? ISSUE : IDLE with row/plane cleared to 0.
//  out_ROW/out_PLANE change only in ADVANCE (or reset/disable); stable through ISSUE..HOLD.
//  Handshake: never assert out_INIT unless previous order fully completed (HOLD finished)
//   and in_HUB_WAITING=1; ISSUE entered with in_HUB_WAITING=0 waits in ISSUE with out_INIT=0.
//  in_ENABLE low mid-order: current order completes through HOLD; ADVANCE then goes IDLE,
//   row/plane/col reset to 0, no FRAME_DONE unless the wrap coincides.
//  in_ENABLE toggling while IDLE with in_HUB_WAITING=0: stays IDLE.
//  Simultaneous in_ITER and in_HUB_WAITING rise in SHIFT: count the ITER, then go HOLD.
//  in_ITER outside SHIFT: ignored.
// CONFIGURATION
//  HUB75_DIM_EN defined: adds port in_DIM [1:0] (in); HOLD load = (BASE_SHOW<<plane)>>in_DIM,
//   clamped to minimum 1; in_DIM sampled at HOLD entry only.
//  HUB75_DIM_EN undefined: no in_DIM port; HOLD load = BASE_SHOW<<plane.
// TESTING  (ROWS=4, PLANES=2, COLS=8, BASE_SHOW=4; driver model: WAITING drops 1 cycle
//  after INIT, 8 ITER pulses, WAITING rises 2 cycles after last ITER)
//  T1 reset: rst=0 mid-SHIFT -> all outputs 0 same cycle (no clock edge needed), IDLE.
//  T2 one order: ENABLE=1 -> out_INIT high 2 cycles, out_COL 0..7 then wraps to 0,
//     HOLD lasts 4 cycles (plane 0), then plane=1 with HOLD 8 cycles.
//  T3 frame: 8 orders (4 rows x 2 planes) -> out_FRAME_DONE single pulse, out_ROW=0, plane=0.
//  T4 slow ack: WAITING stays high 5 cycles after INIT -> out_INIT held 5+ cycles, one order.
//  T5 disable: ENABLE=0 during SHIFT of row 2 -> HOLD completes, IDLE, row=plane=col=0,
//     out_BUSY=0, no further out_INIT.
//  T6 HUB75_DIM_EN: in_DIM=3, plane 0 -> HOLD 1 cycle (4>>3 clamped); plane 1 -> HOLD 1 cycle.

Source files
------------

// File: rtl/hub75_scan_scheduler.sv
// HUB75 frame sequencer: walks rows x BCM bit-planes, issues shift/latch orders, tracks columns and times lit intervals.
// Optional macro HUB75_DIM_EN adds in_DIM, a global brightness right-shift applied to each plane's lit time.
module hub75_scan_scheduler #(
    parameter int ROWS      = 32,
    parameter int PLANES    = 8,
    parameter int COLS      = 64,
    parameter int BASE_SHOW = 64,
    localparam int ROW_BITS   = $clog2(ROWS),
    localparam int PLANE_BITS = $clog2(PLANES),
    localparam int COL_BITS   = $clog2(COLS),
    localparam int HOLD_W     = $clog2(BASE_SHOW * (2 ** (PLANES - 1))) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_ENABLE,
    input  logic                  in_HUB_WAITING,
    input  logic                  in_ITER,
`ifdef HUB75_DIM_EN
    input  logic [1:0]            in_DIM,
`endif
    output logic                  out_INIT,
    output logic [ROW_BITS-1:0]   out_ROW,
    output logic [PLANE_BITS-1:0] out_PLANE,
    output logic [COL_BITS-1:0]   out_COL,
    output logic                  out_FRAME_DONE,
    output logic                  out_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_SHIFT,
        S_HOLD,
        S_ADVANCE
    } state_t;

    localparam logic [ROW_BITS-1:0]   ROW_LAST   = ROW_BITS'(ROWS - 1);
    localparam logic [PLANE_BITS-1:0] PLANE_LAST = PLANE_BITS'(PLANES - 1);
    localparam logic [COL_BITS-1:0]   COL_LAST   = COL_BITS'(COLS - 1);

    state_t                  state_q;
    logic                    init_q;
    logic [ROW_BITS-1:0]     row_q;
    logic [PLANE_BITS-1:0]   plane_q;
    logic [COL_BITS-1:0]     col_q;
    logic                    frame_done_q;
    logic                    busy_q;
    logic [HOLD_W-1:0]       hold_q;

    logic                    last_plane;
    logic                    last_row;
    logic [1:0]              dim_sel;

    assign last_plane = (plane_q == PLANE_LAST);
    assign last_row   = (row_q == ROW_LAST);

`ifdef HUB75_DIM_EN
    assign dim_sel = in_DIM;
`else
    assign dim_sel = 2'd0;
`endif

    // Lit time for a plane, optionally dimmed; never zero so HOLD always terminates.
    function automatic logic [HOLD_W-1:0] hold_load(input logic [PLANE_BITS-1:0] plane,
                                                    input logic [1:0] dim);
        logic [HOLD_W-1:0] full;
        logic [HOLD_W-1:0] shifted;
        full    = HOLD_W'(BASE_SHOW) << plane;
        shifted = full >> dim;
        if (shifted == '0) begin
            shifted = HOLD_W'(1);
        end
        return shifted;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            init_q       <= 1'b0;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            hold_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_ENABLE && in_HUB_WAITING) begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                // An order is only raised once the driver reports it is idle.
                S_ISSUE: begin
                    if (in_HUB_WAITING) begin
                        init_q  <= 1'b1;
                        col_q   <= '0;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!in_HUB_WAITING) begin
                        init_q  <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (in_ITER) begin
                        col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                    end
                    if (in_HUB_WAITING) begin
                        hold_q  <= hold_load(plane_q, dim_sel);
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    hold_q <= hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) begin
                        state_q <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (last_plane && last_row) begin
                        frame_done_q <= 1'b1;
                    end
                    if (in_ENABLE) begin
                        state_q <= S_ISSUE;
                        if (last_plane) begin
                            plane_q <= '0;
                            row_q   <= last_row ? '0 : row_q + 1'b1;
                        end else begin
                            plane_q <= plane_q + 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        row_q   <= '0;
                        plane_q <= '0;
                        col_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    init_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_INIT       = init_q;
    assign out_ROW        = row_q;
    assign out_PLANE      = plane_q;
    assign out_COL        = col_q;
    assign out_FRAME_DONE = frame_done_q;
    assign out_BUSY       = busy_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Directed bench for hub75_scan_scheduler with a small in-line HUB75 driver model (ROWS=4, PLANES=2, COLS=8, BASE_SHOW=4).
module tb_hub75_scan_scheduler;

    localparam int ROWS      = 4;
    localparam int PLANES    = 2;
    localparam int COLS      = 8;
    localparam int BASE_SHOW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       wt  = 1'b1;
    logic       it  = 1'b0;
    logic       init;
    logic [1:0] row;
    logic [0:0] plane;
    logic [2:0] col;
    logic       fd;
    logic       busy;
`ifdef HUB75_DIM_EN
    logic [1:0] dim = 2'd0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hub75_scan_scheduler #(
        .ROWS(ROWS), .PLANES(PLANES), .COLS(COLS), .BASE_SHOW(BASE_SHOW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_ENABLE(en),
        .in_HUB_WAITING(wt),
        .in_ITER(it),
`ifdef HUB75_DIM_EN
        .in_DIM(dim),
`endif
        .out_INIT(init),
        .out_ROW(row),
        .out_PLANE(plane),
        .out_COL(col),
        .out_FRAME_DONE(fd),
        .out_BUSY(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 50; i++) begin
            if (init) break;
            tick();
        end
        check("init_seen", init, 1);
    endtask

    // One complete order as the driver would see it; ack_d = cycles WAITING stays high after INIT.
    task automatic do_order(input int ack_d, input int exp_row, input int exp_plane,
                            input int exp_hold, input bit exp_fd, input bit simul, input bit dis);
        int hi;
        int n;
        wait_init();
        check("row", row, exp_row);
        check("plane", plane, exp_plane);
        check("col_clr", col, 0);
        check("busy_on", busy, 1);
        hi = 0;
        for (int i = 0; i < ack_d; i++) begin
            if (init) hi++;
            tick();
        end
        wt = 1'b0;
        for (int i = 0; i < 20 && init; i++) begin
            hi++;
            tick();
        end
        check("init_len", hi, ack_d + 1);
        for (int k = 0; k < COLS; k++) begin
            it = 1'b1;
            if (dis && k == 0) en = 1'b0;
            if (simul && k == COLS - 1) begin
                wt = 1'b1;
                break;
            end
            tick();
            check("col_step", col, (k + 1) % COLS);
        end
        if (!simul) begin
            it = 1'b0;
            tick();
            wt = 1'b1;
        end
        n = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            n++;
            if (row != exp_row[1:0] || plane != exp_plane[0:0] || !busy) break;
            it = 1'b1;
        end
        it = 1'b0;
        check("hold_len", n - 2, exp_hold);
        check("col_after", col, 0);
        check("frame_done", fd, exp_fd);
        if (dis) begin
            check("busy_off", busy, 0);
            check("dis_row", row, 0);
            check("dis_plane", plane, 0);
        end
        tick();
        check("fd_pulse", fd, 0);
    endtask

    initial begin
        int hi;
        #1 rst = 1'b0;
        #1;
        check("rst_init", init, 0);
        check("rst_row", row, 0);
        check("rst_plane", plane, 0);
        check("rst_col", col, 0);
        check("rst_fd", fd, 0);
        check("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Async reset while shifting columns.
        en = 1'b1;
        wt = 1'b1;
        wait_init();
        tick();
        wt = 1'b0;
        tick();
        it = 1'b1;
        repeat (3) tick();
        it = 1'b0;
        check("t1_col", col, 3);
        check("t1_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t1_init", init, 0);
        check("t1_col0", col, 0);
        check("t1_busy0", busy, 0);
        check("t1_row", row, 0);
        check("t1_fd", fd, 0);
        en = 1'b0;
        wt = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("t1_idle", busy, 0);

        // Full frame; one order has ITER coinciding with WAITING rise.
        en = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < PLANES; p++) begin
                do_order(1, r, p, BASE_SHOW << p, (r == ROWS - 1) && (p == PLANES - 1),
                         (r == 1) && (p == 1), 1'b0);
            end
        end

        // Slow acknowledge, then continue to row 2 and disable mid-shift.
        do_order(5, 0, 0, 4, 1'b0, 1'b0, 1'b0);
        do_order(1, 0, 1, 8, 1'b0, 1'b0, 1'b0);
        do_order(1, 1, 0, 4, 1'b0, 1'b0, 1'b0);
        do_order(1, 1, 1, 8, 1'b0, 1'b0, 1'b0);
        do_order(1, 2, 0, 4, 1'b0, 1'b0, 1'b1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (init || busy) hi++;
            tick();
        end
        check("t5_quiet", hi, 0);

        // Enable toggling while the driver is not waiting must not leave IDLE.
        wt = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            en = i[0];
            tick();
            if (busy || init) hi++;
        end
        check("idle_hold", hi, 0);

`ifdef HUB75_DIM_EN
        dim = 2'd3;
        wt  = 1'b1;
        en  = 1'b1;
        do_order(1, 0, 0, 1, 1'b0, 1'b0, 1'b0);
        do_order(1, 0, 1, 1, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
